// File: rtl/audio_pkg.sv
// audio_pkg: shared widths and fetch FSM states for the audio sample player
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/audio_word_buffer.sv
// audio_word_buffer: current/next word registers with half select, capture, consume and flush
module audio_word_buffer
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                tick_go_i,
  input  logic                cap_i,
  input  logic [WORD_W-1:0]   cap_data_i,
  output logic                cur_valid_o,
  output logic                next_valid_o,
  output logic [SAMPLE_W-1:0] half_o
);
  logic [WORD_W-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic cur_v_q, cur_v_d, nxt_v_q, nxt_v_d, half_q, half_d;
  logic consume, cur_v_t;
  always_comb begin
    consume = tick_go_i && cur_v_q && half_q;
    // a capture sees the buffer as it stands after this cycle's tick
    cur_v_t = consume ? nxt_v_q : cur_v_q;
    cur_d = consume && nxt_v_q ? nxt_q : cur_q;
    nxt_d = nxt_q;
    nxt_v_d = nxt_v_q && !consume;
    half_d = half_q ^ (tick_go_i && cur_v_q);
    cur_v_d = cur_v_t;
    if (cap_i && !cur_v_t) begin
      cur_d = cap_data_i;
      cur_v_d = 1'b1;
      half_d = 1'b0;
    end else if (cap_i) begin
      nxt_d = cap_data_i;
      nxt_v_d = 1'b1;
    end
    if (flush_i) begin
      cur_v_d = 1'b0;
      nxt_v_d = 1'b0;
      half_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      nxt_q <= '0;
      cur_v_q <= 1'b0;
      nxt_v_q <= 1'b0;
      half_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      cur_v_q <= cur_v_d;
      nxt_v_q <= nxt_v_d;
      half_q <= half_d;
    end
  end
  assign cur_valid_o = cur_v_q;
  assign next_valid_o = nxt_v_q;
  assign half_o = half_q ? cur_q[31:16] : cur_q[15:0];
endmodule

// File: rtl/audio_sample_player.sv
// audio_sample_player: fetches words from the reader and plays one attenuated 16-bit sample per tick
module audio_sample_player
  import audio_pkg::*;
#(
  parameter int VOL_W  = 3,
  parameter int UCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                flush,
  input  logic                sample_tick,
  input  logic [VOL_W-1:0]    vol,
  output logic                word_start,
  input  logic                word_done,
  input  logic [WORD_W-1:0]   word_data,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_valid,
  output logic [UCNT_W-1:0]   underrun_cnt
);
  fetch_state_e st_q, st_d;
  logic disc_q, disc_d, valid_q, valid_d;
  logic [SAMPLE_W-1:0] audio_q, audio_d, half;
  logic signed [SAMPLE_W-1:0] atten;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic tick_go, done_in_wait, cap, cur_v, nxt_v;
  audio_word_buffer u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .tick_go_i   (tick_go),
    .cap_i       (cap),
    .cap_data_i  (word_data),
    .cur_valid_o (cur_v),
    .next_valid_o(nxt_v),
    .half_o      (half)
  );
  always_comb begin
    tick_go = sample_tick && enable && !flush;
    done_in_wait = st_q == WAIT && word_done;
    // a word completing during or after a flush belongs to the discarded stream
    cap = done_in_wait && !disc_q && !flush;
    st_d = st_q == IDLE ? (enable && !nxt_v && !flush ? REQ : IDLE)
         : st_q == REQ  ? WAIT
         : (word_done ? IDLE : WAIT);
    disc_d = done_in_wait ? 1'b0 : (flush && st_q != IDLE) ? 1'b1 : disc_q;
    atten = $signed(half) >>> vol;
    audio_d = tick_go ? (cur_v ? atten : '0) : audio_q;
    valid_d = tick_go;
    ucnt_d = ucnt_q + UCNT_W'(tick_go && !cur_v && !(&ucnt_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      disc_q <= 1'b0;
      audio_q <= '0;
      valid_q <= 1'b0;
      ucnt_q <= '0;
    end else begin
      st_q <= st_d;
      disc_q <= disc_d;
      audio_q <= audio_d;
      valid_q <= valid_d;
      ucnt_q <= ucnt_d;
    end
  end
  assign word_start = st_q == REQ;
  assign audio_out = audio_q;
  assign audio_valid = valid_q;
  assign underrun_cnt = ucnt_q;
endmodule

// File: tb/tb_audio_sample_player.sv
// tb_audio_sample_player: directed checks of playback, volume, underrun, flush, pause and reset
module tb_audio_sample_player;
  logic clk, rst, enable, flush, sample_tick, word_start, word_done, audio_valid;
  logic [2:0] vol;
  logic [31:0] word_data, auto_data, man_data;
  logic [15:0] audio_out, underrun_cnt;
  logic ad, md, rd_auto;
  int rd_delay;
  int req_cnt = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] rd_q[$];
  assign word_done = ad | md;
  assign word_data = md ? man_data : auto_data;
  audio_sample_player dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .sample_tick(sample_tick),
    .vol(vol), .word_start(word_start), .word_done(word_done), .word_data(word_data),
    .audio_out(audio_out), .audio_valid(audio_valid), .underrun_cnt(underrun_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input string tag, input logic [15:0] exp);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk({tag, "_valid"}, {31'b0, audio_valid}, 32'd1);
    chk(tag, {16'b0, audio_out}, {16'b0, exp});
  endtask
  task automatic wait_start(input string tag);
    int n = 0;
    while (!word_start && n < 40) begin
      cyc();
      n++;
    end
    chk(tag, {31'b0, word_start}, 32'd1);
  endtask
  task automatic man_word(input logic [31:0] d);
    md = 1'b1;
    man_data = d;
    cyc();
    md = 1'b0;
  endtask
  task automatic reset_dut();
    enable = 1'b0;
    repeat (120) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask
  // auto reader: answers each request after rd_delay idle cycles with the next queued word
  initial begin
    ad = 1'b0;
    auto_data = '0;
    forever begin
      cyc();
      if (word_start) begin
        req_cnt++;
        if (rd_auto) begin
          cyc();
          repeat (rd_delay) cyc();
          auto_data = 32'h0;
          if (rd_q.size() > 0) auto_data = rd_q.pop_front();
          ad = 1'b1;
          cyc();
          ad = 1'b0;
        end
      end
    end
  end
  initial begin
    int r0;
    rst = 1'b1; enable = 1'b0; flush = 1'b0; sample_tick = 1'b0; vol = '0;
    md = 1'b0; man_data = '0; rd_auto = 1'b1; rd_delay = 2;
    repeat (2) cyc();
    chk("rst_word_start", {31'b0, word_start}, 32'd0);
    chk("rst_audio_out", {16'b0, audio_out}, 32'd0);
    chk("rst_audio_valid", {31'b0, audio_valid}, 32'd0);
    chk("rst_underrun", {16'b0, underrun_cnt}, 32'd0);
    rst = 1'b0;
    // steady play
    rd_q = '{32'h1234_ABCD, 32'h0001_FFFF};
    enable = 1'b1;
    repeat (20) cyc();
    tick("steady0", 16'hABCD); repeat (7) cyc();
    tick("steady1", 16'h1234); repeat (7) cyc();
    tick("steady2", 16'hFFFF); repeat (7) cyc();
    tick("steady3", 16'h0001);
    chk("steady_underrun", {16'b0, underrun_cnt}, 32'd0);
    // volume
    reset_dut();
    rd_q = '{32'h8000_4000};
    vol = 3'd2;
    enable = 1'b1;
    repeat (20) cyc();
    tick("vol_lo", 16'h1000); repeat (7) cyc();
    tick("vol_hi", 16'hE000);
    vol = '0;
    // underrun with slow reader
    reset_dut();
    rd_q = '{32'h7777_2222};
    rd_delay = 100;
    enable = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 5; i++) begin
      tick("underrun_zero", 16'h0000);
      repeat (9) cyc();
    end
    chk("underrun_cnt5", {16'b0, underrun_cnt}, 32'd5);
    repeat (70) cyc();
    tick("resume_lo", 16'h2222); repeat (9) cyc();
    tick("resume_hi", 16'h7777);
    chk("underrun_hold", {16'b0, underrun_cnt}, 32'd5);
    // tick consumes last half in the same cycle a word completes
    reset_dut();
    rd_auto = 1'b0;
    enable = 1'b1;
    wait_start("sim_req1");
    cyc();
    man_word(32'h1122_3344);
    wait_start("sim_req2");
    cyc();
    tick("sim_lo", 16'h3344);
    sample_tick = 1'b1;
    man_word(32'hAAAA_5555);
    sample_tick = 1'b0;
    chk("sim_hi_valid", {31'b0, audio_valid}, 32'd1);
    chk("sim_hi", {16'b0, audio_out}, 32'h1122);
    tick("sim_new", 16'h5555);
    chk("sim_underrun", {16'b0, underrun_cnt}, 32'd0);
    // flush while a request is in flight
    reset_dut();
    enable = 1'b1;
    wait_start("fl_req1");
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    r0 = req_cnt;
    repeat (3) cyc();
    chk("fl_no_req", req_cnt, r0);
    man_word(32'hDEAD_BEEF);
    tick("fl_dropped", 16'h0000);
    wait_start("fl_req2");
    cyc();
    chk("fl_req_cnt", req_cnt, r0 + 1);
    man_word(32'h1357_9BDF);
    tick("fl_lo", 16'h9BDF);
    tick("fl_hi", 16'h1357);
    // pause, then reset mid-request
    reset_dut();
    rd_auto = 1'b1;
    rd_delay = 0;
    rd_q = '{32'hCAFE_BEEF, 32'h1234_5678};
    enable = 1'b1;
    repeat (15) cyc();
    tick("pause_lo", 16'hBEEF);
    enable = 1'b0;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk("pause_no_valid", {31'b0, audio_valid}, 32'd0);
    enable = 1'b1;
    tick("pause_hi", 16'hCAFE);
    enable = 1'b0;
    rd_auto = 1'b0;
    r0 = req_cnt;
    repeat (10) cyc();
    chk("pause_no_req", req_cnt, r0);
    enable = 1'b1;
    wait_start("pause_req");
    cyc();
    tick("pause_n_lo", 16'h5678);
    tick("pause_n_hi", 16'h1234);
    rst = 1'b1;
    cyc();
    chk("midrst_word_start", {31'b0, word_start}, 32'd0);
    chk("midrst_audio_out", {16'b0, audio_out}, 32'd0);
    chk("midrst_audio_valid", {31'b0, audio_valid}, 32'd0);
    chk("midrst_underrun", {16'b0, underrun_cnt}, 32'd0);
    rst = 1'b0;
    man_word(32'hFFFF_FFFF);
    tick("midrst_ignored", 16'h0000);
    chk("midrst_underrun1", {16'b0, underrun_cnt}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
